// File: rtl/wm_fsm_param.sv
// Parametrised watermark FSM: passes input through until a keyed unlock sequence,
// then emits a hidden signature chunk by chunk against matching input chunks.
module wm_fsm_param #(
   parameter int                           LEN_I     = 3,
   parameter int                           LEN_O     = 5,
   parameter int                           INIT_LEN  = 4,
   parameter logic [INIT_LEN*LEN_I-1:0]    INIT_KEY  = 12'h29C,
   parameter int                           SIG_BITS  = 128,
   parameter logic [SIG_BITS-1:0]          SIGNATURE = 128'hD41D8CD98F00B204E9800998ECF8427E,
   parameter int                           REARM     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LEN_I-1:0] in,
   output logic [LEN_O-1:0] out,
   output logic             wm_active,
   output logic             wm_done
);

   localparam int W      = LEN_I + LEN_O;
   localparam int NCHUNK = SIG_BITS / W;
   localparam int IDX_W  = $clog2(INIT_LEN + 1);
   localparam int K_W    = $clog2(NCHUNK + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(NCHUNK - 1);

   typedef enum logic [1:0] {LOCK, SIGN, DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [K_W-1:0]   k;

   // Out-of-range indices fold to 0 so the decode never yields X.
   function automatic logic [LEN_I-1:0] key_at(input logic [IDX_W-1:0] i);
      int sel;
      sel = (int'(i) < INIT_LEN) ? int'(i) : 0;
      return LEN_I'(INIT_KEY >> ((INIT_LEN - 1 - sel) * LEN_I));
   endfunction

   function automatic logic [W-1:0] chunk_at(input logic [K_W-1:0] c);
      int sel;
      sel = (int'(c) < NCHUNK) ? int'(c) : 0;
      return W'(SIGNATURE >> (SIG_BITS - (sel + 1) * W));
   endfunction

   logic [W-1:0]     chunk;
   logic [LEN_I-1:0] sig_in;
   logic [LEN_O-1:0] sig_out;
   logic [LEN_O-1:0] base;
   logic             hit_key;
   logic             hit_sig;
   logic [IDX_W-1:0] restart_idx;

   assign chunk       = chunk_at(k);
   assign sig_in      = chunk[W-1 -: LEN_I];
   assign sig_out     = chunk[LEN_O-1:0];
   assign base        = LEN_O'(in);
   assign hit_key     = (in == key_at(idx));
   assign hit_sig     = (in == sig_in);
   // A symbol that breaks the sequence may itself start a new attempt.
   assign restart_idx = (in == key_at('0)) ? IDX_W'(1) : '0;

   always_comb begin
      out = base;
      if (reset)
         out = '0;
      else if (state == SIGN && hit_sig)
         out = sig_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOCK;
         idx       <= '0;
         k         <= '0;
         wm_active <= 1'b0;
         wm_done   <= 1'b0;
      end else begin
         wm_done <= 1'b0;
         case (state)
            LOCK: begin
               if (hit_key) begin
                  if (idx == IDX_LAST) begin
                     state     <= SIGN;
                     idx       <= '0;
                     k         <= '0;
                     wm_active <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else begin
                  idx <= restart_idx;
               end
            end
            SIGN: begin
               if (hit_sig) begin
                  if (k == K_LAST) begin
                     wm_done   <= 1'b1;
                     wm_active <= 1'b0;
                     k         <= '0;
                     idx       <= '0;
                     state     <= (REARM != 0) ? LOCK : DONE;
                  end else begin
                     k <= k + K_W'(1);
                  end
               end else begin
                  state     <= LOCK;
                  idx       <= restart_idx;
                  k         <= '0;
                  wm_active <= 1'b0;
               end
            end
            DONE: state <= DONE;
            default: begin
               state     <= LOCK;
               idx       <= '0;
               k         <= '0;
               wm_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wm_fsm_param.sv
// Bench for wm_fsm_param: vector table on a REARM=0 instance, a re-arm sequence on a
// REARM=1 instance, then random stimulus on both against a behavioural model.
module tb_wm_fsm_param;

   localparam int INIT_LEN = 4;
   localparam int NCHUNK   = 16;
   localparam logic [127:0] SIG = 128'hD41D8CD98F00B204E9800998ECF8427E;
   localparam logic [11:0]  KEY = 12'h29C;

   logic       clk = 1'b0;
   logic       rst0, rst1;
   logic [2:0] in0, in1;
   logic [4:0] out0, out1;
   logic       act0, act1, done0, done1;

   wm_fsm_param #(.REARM(0)) dut0 (
      .clk(clk), .reset(rst0), .in(in0), .out(out0), .wm_active(act0), .wm_done(done0)
   );
   wm_fsm_param #(.REARM(1)) dut1 (
      .clk(clk), .reset(rst1), .in(in1), .out(out1), .wm_active(act1), .wm_done(done1)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [2:0] key_s[INIT_LEN];
   logic [2:0] sin[NCHUNK];
   logic [4:0] sout[NCHUNK];

   logic [4:0] s_o0, s_o1;
   logic       s_a0, s_a1, s_d0, s_d1;

   typedef struct {
      logic       rst;
      logic [2:0] in;
      logic [4:0] eo;
      logic       ea;
      logic       ed;
      string      nm;
   } vec_t;
   vec_t tbl[$];

   // model state per instance
   int m_mode[2];
   int m_k[2];
   int wbuf[2][INIT_LEN];
   int wlen[2];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic r0, input logic [2:0] i0, input logic r1, input logic [2:0] i1);
      rst0 = r0; in0 = i0; rst1 = r1; in1 = i1;
      @(negedge clk);
      s_o0 = out0; s_o1 = out1;
      @(posedge clk);
      #1;
      s_a0 = act0; s_d0 = done0; s_a1 = act1; s_d1 = done1;
   endtask

   task automatic add(input logic r, input logic [2:0] i, input logic [4:0] eo,
                      input logic ea, input logic ed, input string nm);
      vec_t v;
      v.rst = r; v.in = i; v.eo = eo; v.ea = ea; v.ed = ed; v.nm = nm;
      tbl.push_back(v);
   endtask

   task automatic add_keys(input string nm);
      for (int i = 0; i < INIT_LEN - 1; i++) add(0, key_s[i], {2'b00, key_s[i]}, 0, 0, nm);
      add(0, key_s[INIT_LEN-1], {2'b00, key_s[INIT_LEN-1]}, 1, 0, {nm, "_unlock"});
   endtask

   task automatic win_push(input int i, input int s);
      if (wlen[i] < INIT_LEN) begin
         wbuf[i][wlen[i]] = s;
         wlen[i]++;
      end else begin
         for (int j = 0; j < INIT_LEN - 1; j++) wbuf[i][j] = wbuf[i][j+1];
         wbuf[i][INIT_LEN-1] = s;
      end
   endtask

   function automatic bit win_is_key(input int i);
      if (wlen[i] != INIT_LEN) return 0;
      for (int j = 0; j < INIT_LEN; j++) if (wbuf[i][j] != int'(key_s[j])) return 0;
      return 1;
   endfunction

   // Next symbol that advances the instance: longest key prefix ending the window.
   function automatic logic [2:0] good_sym(input int i);
      if (m_mode[i] == 1) return sin[m_k[i]];
      if (m_mode[i] == 2) return 3'($urandom_range(0, 7));
      for (int j = INIT_LEN - 1; j > 0; j--) begin
         bit ok;
         ok = (wlen[i] >= j);
         for (int t = 0; t < j && ok; t++)
            if (wbuf[i][wlen[i] - j + t] != int'(key_s[t])) ok = 0;
         if (ok) return key_s[j];
      end
      return key_s[0];
   endfunction

   task automatic model(input int i, input logic r, input logic [2:0] s, input bit rearm,
                        output logic [4:0] eo, output logic ea, output logic ed);
      ed = 0;
      eo = {2'b00, s};
      if (r) begin
         eo = 0; m_mode[i] = 0; m_k[i] = 0; wlen[i] = 0;
      end else if (m_mode[i] == 0) begin
         win_push(i, int'(s));
         if (win_is_key(i)) begin
            m_mode[i] = 1; m_k[i] = 0; wlen[i] = 0;
         end
      end else if (m_mode[i] == 1) begin
         if (s == sin[m_k[i]]) begin
            eo = sout[m_k[i]];
            m_k[i]++;
            if (m_k[i] == NCHUNK) begin
               ed = 1; m_k[i] = 0; wlen[i] = 0;
               m_mode[i] = rearm ? 0 : 2;
            end
         end else begin
            m_mode[i] = 0; m_k[i] = 0; wlen[i] = 0;
            win_push(i, int'(s));
         end
      end
      ea = (m_mode[i] == 1);
   endtask

   initial begin
      logic [4:0] eo0, eo1;
      logic       ea0, ea1, ed0, ed1;
      logic [7:0] b;

      rst0 = 1; rst1 = 1; in0 = 0; in1 = 0;
      for (int i = 0; i < INIT_LEN; i++) key_s[i] = 3'((KEY >> (9 - 3 * i)) & 12'h7);
      for (int c = 0; c < NCHUNK; c++) begin
         b = 8'((SIG >> (120 - 8 * c)) & 128'hFF);
         sin[c]  = b[7:5];
         sout[c] = b[4:0];
      end

      // vector table, REARM=0 instance
      add(1, 3'd0, 5'h00, 0, 0, "rst_hold0");
      add(1, 3'd5, 5'h00, 0, 0, "rst_hold1");
      add(0, 3'd5, 5'h05, 0, 0, "post_rst_base");
      add_keys("key");
      add(0, 3'd6, 5'h14, 1, 0, "chunk0");
      add(0, 3'd0, 5'h1D, 1, 0, "chunk1");
      add(0, 3'd4, 5'h0C, 1, 0, "chunk2");
      for (int c = 3; c < NCHUNK - 1; c++) add(0, sin[c], sout[c], 1, 0, "chunk_mid");
      add(0, 3'd3, 5'h1E, 0, 1, "chunk15_done");
      add(0, 3'd6, 5'h06, 0, 0, "done_base");
      for (int i = 0; i < INIT_LEN; i++) add(0, key_s[i], {2'b00, key_s[i]}, 0, 0, "done_hold");
      add(1, 3'd6, 5'h00, 0, 0, "rst_from_done");
      add(0, 3'd1, 5'h01, 0, 0, "restart_a");
      add_keys("restart_a");
      add(0, 3'd7, 5'h07, 0, 0, "abort_k0");
      add(0, 3'd1, 5'h01, 0, 0, "restart_b");
      add(0, 3'd2, 5'h02, 0, 0, "restart_b");
      add(0, 3'd5, 5'h05, 0, 0, "restart_b");
      add_keys("restart_b");
      add(0, 3'd6, 5'h14, 1, 0, "abort_c0");
      add(0, 3'd0, 5'h1D, 1, 0, "abort_c1");
      add(0, 3'd7, 5'h07, 0, 0, "abort_k2");
      add(0, 3'd6, 5'h06, 0, 0, "abort_lock");
      add_keys("rekey");
      add(0, 3'd6, 5'h14, 1, 0, "rekey_chunk0");
      for (int c = 1; c < 5; c++) add(0, sin[c], sout[c], 1, 0, "rekey_chunk");
      add(1, 3'd3, 5'h00, 0, 0, "rst_mid_sign");
      add(0, 3'd6, 5'h06, 0, 0, "after_rst_lock");
      add_keys("rekey2");
      add(0, 3'd6, 5'h14, 1, 0, "rekey2_chunk0");

      for (int n = 0; n < tbl.size(); n++) begin
         cyc(tbl[n].rst, tbl[n].in, 1'b1, 3'd0);
         check({tbl[n].nm, "_out"},    32'(s_o0), 32'(tbl[n].eo));
         check({tbl[n].nm, "_active"}, 32'(s_a0), 32'(tbl[n].ea));
         check({tbl[n].nm, "_done"},   32'(s_d0), 32'(tbl[n].ed));
      end

      // re-arm sequence, REARM=1 instance
      cyc(1, 3'd0, 1, 3'd0);
      cyc(1, 3'd0, 1, 3'd0);
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < INIT_LEN; i++) begin
            cyc(1, 3'd0, 0, key_s[i]);
            check("rearm_key_out", 32'(s_o1), 32'(key_s[i]));
            check("rearm_key_active", 32'(s_a1), (i == INIT_LEN - 1) ? 32'd1 : 32'd0);
         end
         for (int c = 0; c < NCHUNK; c++) begin
            cyc(1, 3'd0, 0, sin[c]);
            check("rearm_sig_out", 32'(s_o1), 32'(sout[c]));
            check("rearm_sig_active", 32'(s_a1), (c == NCHUNK - 1) ? 32'd0 : 32'd1);
            check("rearm_sig_done", 32'(s_d1), (c == NCHUNK - 1) ? 32'd1 : 32'd0);
         end
         for (int r = 0; r < 2; r++) begin
            cyc(1, 3'd0, 0, 3'd6);
            check("rearm_lock_out", 32'(s_o1), 32'h06);
            check("rearm_lock_active", 32'(s_a1), 32'd0);
            check("rearm_lock_done", 32'(s_d1), 32'd0);
         end
      end

      // random stimulus on both instances against the model
      cyc(1, 3'd0, 1, 3'd0);
      model(0, 1, 3'd0, 0, eo0, ea0, ed0);
      model(1, 1, 3'd0, 1, eo1, ea1, ed1);
      for (int n = 0; n < 2000; n++) begin
         logic       r;
         logic [2:0] s;
         r = ($urandom_range(0, 99) < 3);
         s = ($urandom_range(0, 9) < 8) ? good_sym((n % 3 == 0) ? 0 : 1) : 3'($urandom_range(0, 7));
         model(0, r, s, 0, eo0, ea0, ed0);
         model(1, r, s, 1, eo1, ea1, ed1);
         cyc(r, s, r, s);
         check("rnd0_out", 32'(s_o0), 32'(eo0));
         check("rnd0_active", 32'(s_a0), 32'(ea0));
         check("rnd0_done", 32'(s_d0), 32'(ed0));
         check("rnd1_out", 32'(s_o1), 32'(eo1));
         check("rnd1_active", 32'(s_a1), 32'(ea1));
         check("rnd1_done", 32'(s_d1), 32'(ed1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
